// File: rtl/csr_access_ctrl_if.sv
// csr_access_ctrl_if: bundles the execute-stage request/response signals and the
// csr_unit bus used by csr_access_ctrl.
//   Request  : start, funct3, csr_addr, rs1_data, zimm, rs1_is_x0, cur_priv
//   Response : busy, done, rd_data, illegal
//   CSR bus  : csr_i_imm, csr_wr, csr_din (to csr_unit), csr_dout (from csr_unit)
// modport master : the access controller (drives busy/done/rd_data/illegal and the CSR bus)
// modport slave  : the environment (execute stage plus csr_unit)
interface csr_access_ctrl_if #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 12
);
  logic              start;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] csr_addr;
  logic [XLEN-1:0]   rs1_data;
  logic [4:0]        zimm;
  logic              rs1_is_x0;
  logic [1:0]        cur_priv;
  logic              busy;
  logic              done;
  logic [XLEN-1:0]   rd_data;
  logic              illegal;
  logic [ADDR_W-1:0] csr_i_imm;
  logic              csr_wr;
  logic [XLEN-1:0]   csr_din;
  logic [XLEN-1:0]   csr_dout;

  modport master (
    input  start, funct3, csr_addr, rs1_data, zimm, rs1_is_x0, cur_priv, csr_dout,
    output busy, done, rd_data, illegal, csr_i_imm, csr_wr, csr_din
  );

  modport slave (
    output start, funct3, csr_addr, rs1_data, zimm, rs1_is_x0, cur_priv, csr_dout,
    input  busy, done, rd_data, illegal, csr_i_imm, csr_wr, csr_din
  );
endinterface

// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: core-side initiator for Zicsr instructions. Latches one decoded
// CSR instruction and runs a fixed read -> modify -> write -> done sequence against
// csr_unit, returning the old CSR value and flagging illegal accesses.
// Ports:
//   clk_i  : system clock
//   rst_i  : synchronous, active-high reset
//   bus    : csr_access_ctrl_if.master (request, response and csr_unit bus)
// Latency: start accepted in cycle N -> csr_wr in N+2 -> done in N+3.
// Configuration macro CSR_PRIV_CHECK_EN: when defined, privilege and read-only
// checks raise illegal; when undefined only funct3[1:0]==00 is illegal.
module csr_access_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk_i,
  input  logic              rst_i,
  csr_access_ctrl_if.master bus
);

  typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [XLEN-1:0]   src_q, src_d;
  logic [XLEN-1:0]   old_q, old_d;
  logic              wr_intent_q, wr_intent_d;
  logic              illegal_q, illegal_d;
  logic              illegal_eval;
  logic [XLEN-1:0]   src_in;
  logic              wr_intent_in;

  // Immediate forms take the zero-extended zimm field as the source operand.
  assign src_in = bus.funct3[2] ? {{(XLEN-5){1'b0}}, bus.zimm} : bus.rs1_data;

  // RW forms always write; set/clear forms write only with a nonzero source field.
  assign wr_intent_in = (bus.funct3[1:0] == 2'b01) ||
                        (bus.funct3[2] ? (bus.zimm != 5'd0) : !bus.rs1_is_x0);

`ifdef CSR_PRIV_CHECK_EN
  logic [1:0] priv_q, priv_d;

  assign priv_d = (state_q == StIdle && bus.start) ? bus.cur_priv : priv_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      priv_q <= 2'b00;
    end else begin
      priv_q <= priv_d;
    end
  end

  // addr[9:8] encodes the lowest privilege allowed; addr[11:10]==11 is read-only.
  assign illegal_eval = (funct3_q[1:0] == 2'b00) ||
                        (addr_q[9:8] > priv_q) ||
                        ((addr_q[11:10] == 2'b11) && wr_intent_q);
`else
  logic unused_cur_priv;
  assign unused_cur_priv = ^bus.cur_priv;
  assign illegal_eval    = (funct3_q[1:0] == 2'b00);
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      funct3_q    <= 3'b000;
      addr_q      <= '0;
      src_q       <= '0;
      old_q       <= '0;
      wr_intent_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      funct3_q    <= funct3_d;
      addr_q      <= addr_d;
      src_q       <= src_d;
      old_q       <= old_d;
      wr_intent_q <= wr_intent_d;
      illegal_q   <= illegal_d;
    end
  end

  // The address register doubles as the csr_unit address, so it stays stable
  // through READ and WRITE.
  assign bus.csr_i_imm = addr_q;

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    src_d       = src_q;
    old_d       = old_q;
    wr_intent_d = wr_intent_q;
    illegal_d   = illegal_q;
    bus.busy    = 1'b0;
    bus.done    = 1'b0;
    bus.rd_data = '0;
    bus.illegal = 1'b0;
    bus.csr_wr  = 1'b0;
    bus.csr_din = '0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          funct3_d    = bus.funct3;
          addr_d      = bus.csr_addr;
          src_d       = src_in;
          wr_intent_d = wr_intent_in;
          state_d     = StRead;
        end
      end
      StRead: begin
        bus.busy  = 1'b1;
        old_d     = bus.csr_dout;
        illegal_d = illegal_eval;
        state_d   = StWrite;
      end
      StWrite: begin
        bus.busy   = 1'b1;
        bus.csr_wr = wr_intent_q && !illegal_q;
        case (funct3_q[1:0])
          2'b01:   bus.csr_din = src_q;
          2'b10:   bus.csr_din = old_q | src_q;
          2'b11:   bus.csr_din = old_q & ~src_q;
          default: bus.csr_din = '0;
        endcase
        state_d = StDone;
      end
      StDone: begin
        bus.busy    = 1'b1;
        bus.done    = 1'b1;
        bus.rd_data = illegal_q ? '0 : old_q;
        bus.illegal = illegal_q;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule

// File: tb/tb_csr_access_ctrl.sv
module tb_csr_access_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  csr_access_ctrl_if #(.XLEN(32), .ADDR_W(12)) bus ();

  csr_access_ctrl #(.XLEN(32), .ADDR_W(12)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: ISA-level meaning of one Zicsr instruction.
  function automatic void model(input logic [2:0] f3, input logic [11:0] a,
                                input logic [31:0] rs1, input logic [4:0] zi, input logic x0,
                                input logic [1:0] pr, input logic [31:0] old,
                                output logic ewr, output logic [31:0] edin,
                                output logic [31:0] erd, output logic eill);
    logic [31:0] src;
    logic        writes;
    src    = f3[2] ? {27'd0, zi} : rs1;
    writes = (f3[1:0] == 2'b01) || (f3[2] ? (zi != 0) : !x0);
    eill   = (f3[1:0] == 2'b00);
`ifdef CSR_PRIV_CHECK_EN
    if (int'(a[9:8]) > int'(pr)) eill = 1'b1;
    if (a[11:10] == 2'b11 && writes) eill = 1'b1;
`endif
    ewr = writes && !eill;
    if (f3[1:0] == 2'b01)      edin = src;
    else if (f3[1:0] == 2'b10) edin = old | src;
    else                       edin = old & ~src;
    erd = eill ? 32'd0 : old;
  endfunction

  task automatic scramble();
    bus.funct3    = 3'($urandom);
    bus.csr_addr  = 12'($urandom);
    bus.rs1_data  = $urandom;
    bus.zimm      = 5'($urandom);
    bus.rs1_is_x0 = 1'($urandom);
    bus.cur_priv  = 2'($urandom);
  endtask

  // Called at a negedge with the DUT idle.
  task automatic do_op(input string tag, input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] rs1, input logic [4:0] zi, input logic x0,
                       input logic [1:0] pr, input logic [31:0] old, input bit hold);
    logic ewr, eill;
    logic [31:0] edin, erd;
    model(f3, a, rs1, zi, x0, pr, old, ewr, edin, erd, eill);
    bus.start = 1'b1; bus.funct3 = f3; bus.csr_addr = a; bus.rs1_data = rs1;
    bus.zimm = zi; bus.rs1_is_x0 = x0; bus.cur_priv = pr; bus.csr_dout = old;
    @(posedge clk); #1;
    if (!hold) bus.start = 1'b0;
    scramble();
    @(negedge clk);
    chk({tag, ".read_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, ".read_addr"}, 32'(bus.csr_i_imm), 32'(a));
    chk({tag, ".read_wr"}, 32'(bus.csr_wr), 32'd0);
    chk({tag, ".read_done"}, 32'(bus.done), 32'd0);
    @(posedge clk); #1;
    bus.csr_dout = $urandom;
    @(negedge clk);
    chk({tag, ".write_wr"}, 32'(bus.csr_wr), 32'(ewr));
    if (ewr) chk({tag, ".write_din"}, bus.csr_din, edin);
    chk({tag, ".write_addr"}, 32'(bus.csr_i_imm), 32'(a));
    chk({tag, ".write_done"}, 32'(bus.done), 32'd0);
    @(negedge clk);
    chk({tag, ".done"}, 32'(bus.done), 32'd1);
    chk({tag, ".rd_data"}, bus.rd_data, erd);
    chk({tag, ".illegal"}, 32'(bus.illegal), 32'(eill));
    chk({tag, ".done_wr"}, 32'(bus.csr_wr), 32'd0);
    chk({tag, ".done_busy"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    chk({tag, ".idle_busy"}, 32'(bus.busy), 32'd0);
    chk({tag, ".idle_done"}, 32'(bus.done), 32'd0);
    bus.start = 1'b0;
  endtask

  initial begin
    logic [1:0]  privs [3];
    logic [2:0]  f3r;
    logic [11:0] ar;
    privs[0] = 2'd0; privs[1] = 2'd1; privs[2] = 2'd3;
    bus.start = 1'b0; bus.funct3 = 3'd0; bus.csr_addr = 12'd0; bus.rs1_data = 32'd0;
    bus.zimm = 5'd0; bus.rs1_is_x0 = 1'b0; bus.cur_priv = 2'd3; bus.csr_dout = 32'd0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.busy", 32'(bus.busy), 32'd0);
    chk("reset.done", 32'(bus.done), 32'd0);
    chk("reset.rd_data", bus.rd_data, 32'd0);
    chk("reset.illegal", 32'(bus.illegal), 32'd0);
    chk("reset.csr_wr", 32'(bus.csr_wr), 32'd0);
    chk("reset.csr_i_imm", 32'(bus.csr_i_imm), 32'd0);
    chk("reset.csr_din", bus.csr_din, 32'd0);

    do_op("rw_340",   3'b001, 12'h340, 32'hDEADBEEF, 5'd0,  1'b0, 2'd3, 32'h12345678, 1'b0);
    do_op("rs_300",   3'b010, 12'h300, 32'h8,        5'd0,  1'b0, 2'd3, 32'h1800,     1'b0);
    do_op("rs_x0",    3'b010, 12'h300, 32'h8,        5'd0,  1'b1, 2'd3, 32'h1800,     1'b0);
    do_op("rci_344",  3'b111, 12'h344, 32'h0,        5'h1F, 1'b0, 2'd3, 32'hFFFF,     1'b0);
    do_op("rwi_zero", 3'b101, 12'h344, 32'hFFFFFFFF, 5'd0,  1'b0, 2'd3, 32'hABCD,     1'b0);
    do_op("rw_upriv", 3'b001, 12'h300, 32'h5,        5'd0,  1'b0, 2'd0, 32'h77,       1'b0);
    do_op("rs_ro_x0", 3'b010, 12'hF14, 32'h5,        5'd0,  1'b1, 2'd3, 32'h2A,       1'b0);
    do_op("rw_ro",    3'b001, 12'hF14, 32'h5,        5'd0,  1'b0, 2'd3, 32'h2A,       1'b0);
    do_op("f3_100",   3'b100, 12'h340, 32'h5,        5'd3,  1'b0, 2'd3, 32'h99,       1'b0);
    do_op("f3_000",   3'b000, 12'h340, 32'h5,        5'd3,  1'b0, 2'd3, 32'h99,       1'b0);
    do_op("hold",     3'b011, 12'h340, 32'hF0,       5'd0,  1'b0, 2'd3, 32'hFF,       1'b1);

    // Reset during READ aborts the access without any write or done.
    bus.start = 1'b1; bus.funct3 = 3'b001; bus.csr_addr = 12'h340; bus.rs1_data = 32'h1;
    bus.rs1_is_x0 = 1'b0; bus.cur_priv = 2'd3; bus.csr_dout = 32'h5;
    @(posedge clk); #1 bus.start = 1'b0;
    @(negedge clk);
    chk("abort.read_busy", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort.busy", 32'(bus.busy), 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("abort.no_wr", 32'(bus.csr_wr), 32'd0);
      chk("abort.no_done", 32'(bus.done), 32'd0);
      @(negedge clk);
    end

    for (int i = 0; i < 200; i++) begin
      f3r = 3'($urandom);
      ar  = 12'($urandom);
      do_op("random", f3r, ar, $urandom, 5'($urandom), 1'($urandom_range(0, 1)),
            privs[$urandom_range(0, 2)], $urandom, bit'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
